// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around the 1-bit full_adder
// cell. Operands are consumed LSB first, one bit pair per clock. The carry
// stays in a flip-flop between bits, and the sum is assembled in a shift
// register.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port.
//   With sub=1 the block computes in1 - in2 - cin, using ~in2 and ~cin.

// 1-bit full adder cell.
module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = in1 ^ in2 ^ cin;
  assign cout = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // Counter is wide enough to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CW-1:0]    count;

  logic fa_sum;
  logic fa_cout;

  // The cell always sees the current LSB pair and the stored carry.
  full_adder u_cell (
    .in1  (a_sr[0]),
    .in2  (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Control FSM plus datapath registers. All outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      result   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= SHIFT;
            busy   <= 1'b1;
            a_sr   <= in1;
`ifdef SERIAL_ADDER_SUB_EN
            b_sr   <= sub ? ~in2 : in2;
            carry  <= sub ? ~cin : cin;
`else
            b_sr   <= in2;
            carry  <= cin;
`endif
            count  <= '0;
            result <= '0;
          end
        end
        SHIFT: begin
          result <= {fa_sum, result[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_cout;
          count  <= count + CW'(1);
          if (count == LAST_BIT) begin
            // The stored carry is the carry into the MSB at this point.
            // It is used directly as msb_cin for the overflow rule.
            state    <= DONE;
            sum      <= {fa_sum, result[WIDTH-1:1]};
            cout     <= fa_cout;
            overflow <= carry ^ fa_cout;
            done     <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8). Runs table-driven vectors plus
// hand-written sequences for busy protection and reset mid-operation.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       s;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Runs one operation. It checks latency, pulse count, busy span and result.
  task automatic run_vec(input vec_t v);
    int lat, pulses, busy_cnt;
    logic [7:0] got_sum;
    logic got_cout, got_ovf;
    lat = 0; pulses = 0; busy_cnt = 0;
    got_sum = 'x; got_cout = 1'bx; got_ovf = 1'bx;
    @(negedge clk);
    in1 = v.a; in2 = v.b; cin = v.c;
`ifdef SERIAL_ADDER_SUB_EN
    sub = v.s;
`endif
    start = 1'b1;
    @(posedge clk); #1;            // E0
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat = k; got_sum = sum; got_cout = cout; got_ovf = overflow;
        end
      end
    end
    $display("op a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d lat=%0d",
             v.a, v.b, v.c, v.s, got_sum, got_cout, got_ovf, lat);
    check("latency", lat, 8);
    check("done_pulses", pulses, 1);
    check("busy_span", busy_cnt, 9);
    check("sum", {24'd0, got_sum}, {24'd0, v.exp_sum});
    check("cout", {31'd0, got_cout}, {31'd0, v.exp_cout});
    check("overflow", {31'd0, got_ovf}, {31'd0, v.exp_ovf});
    check("sum_hold", {24'd0, sum}, {24'd0, v.exp_sum});
  endtask

  vec_t vecs[8];

  initial begin
    int first_done, second_done, pulses;
    logic [7:0] s1, s2;
    logic c2;

    vecs[0] = '{a:8'h0F, b:8'h01, c:1'b0, s:1'b0, exp_sum:8'h10, exp_cout:1'b0, exp_ovf:1'b0};
    vecs[1] = '{a:8'hFF, b:8'h01, c:1'b0, s:1'b0, exp_sum:8'h00, exp_cout:1'b1, exp_ovf:1'b0};
    vecs[2] = '{a:8'h00, b:8'h00, c:1'b1, s:1'b0, exp_sum:8'h01, exp_cout:1'b0, exp_ovf:1'b0};
    vecs[3] = '{a:8'h7F, b:8'h01, c:1'b0, s:1'b0, exp_sum:8'h80, exp_cout:1'b0, exp_ovf:1'b1};
    vecs[4] = '{a:8'h80, b:8'h80, c:1'b0, s:1'b0, exp_sum:8'h00, exp_cout:1'b1, exp_ovf:1'b1};
    vecs[5] = '{a:8'h55, b:8'h55, c:1'b0, s:1'b0, exp_sum:8'hAA, exp_cout:1'b0, exp_ovf:1'b1};
    vecs[6] = '{a:8'hA5, b:8'h5A, c:1'b1, s:1'b0, exp_sum:8'h00, exp_cout:1'b1, exp_ovf:1'b0};
    vecs[7] = '{a:8'h05, b:8'h07, c:1'b0, s:1'b1, exp_sum:8'hFE, exp_cout:1'b0, exp_ovf:1'b0};

    // Reset state
    #2;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
`ifndef SERIAL_ADDER_SUB_EN
      if (vecs[i].s) continue;
`endif
      run_vec(vecs[i]);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_vec('{a:8'h80, b:8'h01, c:1'b0, s:1'b1, exp_sum:8'h7F, exp_cout:1'b1, exp_ovf:1'b1});
    sub = 1'b0;
`endif

    // Busy protection. Start stays high and the operands change during SHIFT.
    first_done = 0; second_done = 0; pulses = 0; s1 = '0; s2 = '0; c2 = 1'bx;
    @(negedge clk);
    in1 = 8'h12; in2 = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;            // E0
    in1 = 8'hAA; in2 = 8'h55;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (k == 9) check("busy_prot_idle", {31'd0, busy}, 0);
      if (k == 10) begin
        check("busy_prot_restart", {31'd0, busy}, 1);
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (first_done == 0) begin first_done = k; s1 = sum; end
        else if (second_done == 0) begin second_done = k; s2 = sum; c2 = cout; end
      end
    end
    $display("busy_prot first=%0d sum=%02h second=%0d sum=%02h cout=%0d", first_done, s1, second_done, s2, c2);
    check("busy_prot_first_at", first_done, 8);
    check("busy_prot_first_sum", {24'd0, s1}, 32'h46);
    check("busy_prot_second_at", second_done, 18);
    check("busy_prot_second_sum", {24'd0, s2}, 32'hFF);
    check("busy_prot_second_cout", {31'd0, c2}, 0);
    check("busy_prot_pulses", pulses, 2);

    // Reset mid-operation, after 4 bits.
    pulses = 0;
    @(negedge clk);
    in1 = 8'h0F; in2 = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;            // E0
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    rst = 1'b1;
    #1;
    $display("midrst busy=%0d done=%0d sum=%02h cout=%0d ovf=%0d", busy, done, sum, cout, overflow);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_sum", {24'd0, sum}, 0);
    check("midrst_cout", {31'd0, cout}, 0);
    check("midrst_ovf", {31'd0, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    run_vec('{a:8'h03, b:8'h04, c:1'b0, s:1'b0, exp_sum:8'h07, exp_cout:1'b0, exp_ovf:1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
